// File: rtl/ac_modport.sv
// ac_modport: unsigned running accumulator.
// Each rising clk edge with rst high adds the zero-extended `in` to `sum`.
// Overflow either wraps modulo 2^SUM_W or clamps at all-ones (SATURATE=1).
// `sum` is the only state and comes straight from a flop.
//
// Reset release is expected to arrive already synchronised to clk, so no
// extra synchroniser stage sits in front of the flop. The first edge that
// sees rst high accumulates. An edge that coincides with the release does not.
module ac_modport #(
    parameter int IN_W     = 8,
    parameter int SUM_W    = 16,   // must be >= IN_W
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,  // asynchronous, active-low
    input  logic [IN_W-1:0]  in,
    output logic [SUM_W-1:0] sum
);

    // One extra bit keeps the carry, so overflow detection is exact.
    logic [SUM_W:0]   next_wide;
    logic [SUM_W-1:0] sum_next;

    assign next_wide = {1'b0, sum} + {{(SUM_W + 1 - IN_W){1'b0}}, in};

    // Choose between the wrapped sum and the clamp value for the next total.
    always_comb begin
        sum_next = next_wide[SUM_W-1:0];
        if (SATURATE && next_wide[SUM_W]) begin
            sum_next = '1;
        end
    end

    // Running total register; asynchronous clear discards any partial total.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else begin
            sum <= sum_next;
        end
    end

endmodule

// File: tb/tb_ac_modport.sv
// Bench for ac_modport.
// A wrap instance and a saturate instance share the same stimulus.
// The model keeps the true unbounded total as a plain integer.
// The wrapped value is that total modulo 2^16.
// The saturated value is min(total, 2^16-1).
module tb_ac_modport;

  localparam int IN_W  = 8;
  localparam int SUM_W = 16;
  localparam longint MOD = 65536;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in;
  logic [SUM_W-1:0] sum_w;
  logic [SUM_W-1:0] sum_s;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint total    = 0;   // true unbounded total since the last reset
  bit     cmp_en   = 0;

  ac_modport #(.IN_W(IN_W), .SUM_W(SUM_W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in(in), .sum(sum_w)
  );

  ac_modport #(.IN_W(IN_W), .SUM_W(SUM_W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in(in), .sum(sum_s)
  );

  // Clock / reset block: 10 time-unit period, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SUM_W-1:0] exp_wrap();
    return SUM_W'(total % MOD);
  endfunction

  function automatic logic [SUM_W-1:0] exp_sat();
    return (total > MOD - 1) ? 16'hFFFF : SUM_W'(total);
  endfunction

  task automatic chk(input string name, input logic [SUM_W-1:0] act,
                     input logic [SUM_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Compare process: on every falling edge, check both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wrap_model", sum_w, exp_wrap());
      chk("sat_model",  sum_s, exp_sat());
    end
  end

  // Driver: starts at posedge+2. It presents v and lets one rising edge pass.
  // The model takes the addend only while rst is high. It ends at posedge+2.
  task automatic step(input logic [IN_W-1:0] v);
    in = v;
    @(posedge clk);
    if (rst) total += longint'(v);
    #2;
  endtask

  // Asynchronous reset pulse between edges. The outputs must clear before the next edge.
  // Release happens at posedge+2 after one edge in reset.
  task automatic pulse_reset(input string name);
    rst   = 1'b0;
    total = 0;
    #1;
    chk({name, "_wrap_async0"}, sum_w, 16'h0000);
    chk({name, "_sat_async0"},  sum_s, 16'h0000);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Power-up: create a real falling edge on rst.
    rst = 1'b1;
    in  = 8'hFF;
    #1 rst = 1'b0;
    cmp_en = 1;
    @(posedge clk); #2;

    // Held in reset for 2 cycles with in=FF: the outputs stay 0.
    step(8'hFF);
    step(8'hFF);
    chk("reset_hold_wrap", sum_w, 16'h0000);
    chk("reset_hold_sat",  sum_s, 16'h0000);

    // Release between edges, then accumulate 1,2,3,4.
    rst = 1'b1;
    step(8'd1); chk("acc1", sum_w, 16'd1);
    step(8'd2); chk("acc2", sum_w, 16'd3);
    step(8'd3); chk("acc3", sum_w, 16'd6);
    step(8'd4); chk("acc4", sum_w, 16'd10);

    // in=0 holds the value.
    for (int i = 0; i < 3; i++) step(8'd0);
    chk("hold_wrap", sum_w, 16'd10);
    chk("hold_sat",  sum_s, 16'd10);

    // Wrap and saturate boundaries: 257 x 255 = 65535 exactly.
    pulse_reset("pre_wrap");
    for (int i = 0; i < 257; i++) step(8'd255);
    chk("full_wrap", sum_w, 16'hFFFF);
    chk("full_sat",  sum_s, 16'hFFFF);
    step(8'd1);
    chk("wrap_to_zero", sum_w, 16'h0000);
    chk("sat_clamp",    sum_s, 16'hFFFF);
    for (int i = 0; i < 10; i++) step(8'd255);
    chk("sat_held", sum_s, 16'hFFFF);
    chk("wrap_after", sum_w, 16'd2550);
    pulse_reset("sat_clear");

    // Reset in the middle of an accumulation.
    for (int i = 0; i < 5; i++) step(8'd100);
    chk("mid_500", sum_w, 16'd500);
    pulse_reset("mid");
    step(8'd7);
    chk("resume_wrap", sum_w, 16'd7);
    chk("resume_sat",  sum_s, 16'd7);

    // Randomised stream with occasional resets. Large values are biased so
    // that both wrap and saturation occur.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset("rand");
      end else if ($urandom_range(0, 1) == 0) begin
        step(IN_W'($urandom_range(200, 255)));
      end else begin
        step(IN_W'($urandom_range(0, 255)));
      end
    end

    @(negedge clk);
    cmp_en = 0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ac_modport.md
AC_MODPORT -- requirements
Module: ac_modport

Interface
REQ-001 Clocking: the block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter IN_W, 8, input operand width in bits.
REQ-003 Parameter SUM_W, 16, accumulator/output width in bits; SUM_W >= IN_W.
REQ-004 Parameter SATURATE, 0, overflow mode: 0 = wrap modulo 2^SUM_W, 1 = clamp at 2^SUM_W-1.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-007 Port in  input  IN_W  unsigned addend, sampled every rising clk edge while rst=1.
REQ-008 Port sum  output  SUM_W  registered running total, driven directly from a flop.

Function
REQ-009 Operation: on each rising clk edge with rst=1, sum SHALL load sum + in.
- in zero-extended to SUM_W; unsigned arithmetic.
REQ-010 No enable or valid qualifier: every clock edge with rst=1 accumulates; in=0 holds the value.
REQ-011 Latency: in sampled at edge k SHALL be reflected in sum immediately after edge k (one-cycle registered latency); no combinational path from in to sum.
REQ-012 Wrap mode (SATURATE=0): the sum SHALL be computed modulo 2^SUM_W; carry out of bit SUM_W-1 is discarded silently.
REQ-013 Saturate mode (SATURATE=1): if the true sum exceeds 2^SUM_W-1, sum SHALL load 2^SUM_W-1 and hold there while in>0.
- Saturate mode: sum leaves 2^SUM_W-1 only through reset.
REQ-014 The next-value computation SHALL use a SUM_W+1-bit intermediate so overflow detection is exact.
REQ-015 X/Z on in while rst=1 is illegal stimulus; the design need not define the result.

Reset
REQ-016 When rst goes to 0, sum SHALL clear to 0 immediately, independent of clk.
REQ-017 While rst=0, sum SHALL hold 0 and in SHALL be ignored.
REQ-018 Reset release: release of rst SHALL be synchronized to clk.
- First accumulation occurs at the first rising edge where rst is sampled 1.
- An edge coincident with deassertion does not accumulate.
REQ-019 Reset asserted mid-accumulation SHALL discard the running total with no partial update.
- After release, accumulation resumes from 0.
REQ-020 No other internal state exists; sum is the sole state register.

Verification
REQ-021 Reset: hold rst=0 for 2 cycles with in=8'hFF -> sum=16'h0000 throughout; assert rst asynchronously between edges -> sum=0 before the next edge.
REQ-022 Basic accumulate: release rst, drive in=1,2,3,4 on consecutive edges -> sum=1,3,6,10 after each respective edge.
REQ-023 Hold: from sum=10, drive in=0 for 3 cycles -> sum stays 10.
REQ-024 Wrap (SATURATE=0): drive in=255 for 257 edges after reset -> sum=65535 after edge 257; one more in=1 -> sum=0.
REQ-025 Saturate (SATURATE=1): same 257 x 255 stream plus 10 more edges of in=255 -> sum=65535 and held; then rst=0 -> sum=0.
REQ-026 Reset mid-stream: accumulate in=100 for 5 edges (sum=500), pulse rst=0 between edges, release, drive in=7 -> sum=0 during reset, then 7.
